// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and data paths; data has priority, fetch is starvation-protected.
// Latency: 2 + BUS cycles from grant in IDLE to the one-cycle ready pulse (3 cycles minimum with zero-wait memory).
// Backpressure: requesters hold req until their ready pulse; memory stalls via mem_ack, bounded by TIMEOUT.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              bus_err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;        // 1 = data path owns the bus
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              bus_err_q, bus_err_d;
  logic              busy_q, busy_d;
  logic              fetch_forced;

  // Fetch wins over a pending data request once data has been granted STARVE_LIMIT times in a row.
  assign fetch_forced = if_req && (starve_cnt_q == SW'(STARVE_LIMIT));

  // Next-state and registered-output logic; ready/bus_err are set on entry to DONE so they pulse during DONE.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;
    bus_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (d_req && !fetch_forced) begin
          owner_d     = 1'b1;
          mem_addr_d  = d_addr;
          mem_we_d    = d_we;
          mem_wdata_d = d_wdata;
          mem_req_d   = 1'b1;
          wait_cnt_d  = '0;
          state_d     = S_BUS;
          if (!if_req)
            starve_cnt_d = '0;
          else if (starve_cnt_q != SW'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt_q + 1'b1;
        end else if (if_req) begin
          owner_d      = 1'b0;
          mem_addr_d   = if_addr;
          mem_we_d     = 1'b0;
          mem_req_d    = 1'b1;
          wait_cnt_d   = '0;
          starve_cnt_d = '0;
          state_d      = S_BUS;
        end
      end

      S_BUS: begin
        if (mem_ack || (wait_cnt_q == WW'(TIMEOUT - 1))) begin
          // A late ack in the final allowed cycle still completes normally.
          if (owner_q) begin
            if (!mem_ack)       d_rdata_d = '0;
            else if (!mem_we_q) d_rdata_d = mem_rdata;
            d_ready_d = 1'b1;
          end else begin
            if_rdata_d = mem_ack ? mem_rdata : '0;
            if_ready_d = 1'b1;
          end
          bus_err_d = !mem_ack;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      starve_cnt_q <= '0;
      wait_cnt_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
      bus_err_q    <= bus_err_d;
      busy_q       <= busy_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign bus_err   = bus_err_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares a single-port unified memory between the instruction-fetch path and the data (load/store) path of the 5-stage pipeline.
- Arbitration is fixed priority, data over fetch, with an anti-starvation limit.
- Each access runs as a registered request/acknowledge transaction on the memory side.
- Each requester sees a one-cycle ready pulse on completion; the pipeline holds its stage stalled until that pulse.

Parameters:
- ADDR_W, 32, address width of requesters and memory bus.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced.
- TIMEOUT, 64, max BUS cycles waiting for mem_ack before the transaction is aborted with error.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address, stable while if_req=1
- if_rdata  out  DATA_W  fetched word, valid when if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid when d_ready=1 and the access was a load
- d_ready  out  1  one-cycle completion pulse for data
- bus_err  out  1  pulses with the ready pulse when the transaction timed out
- busy  out  1  1 when state is not IDLE
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, sampled only in BUS

Behaviour:
- Reset (reset=0 at a rising edge):
  - State goes to IDLE.
  - All outputs are forced to 0: rdata, ready, bus_err, busy, mem_req, mem_we, mem_addr, mem_wdata.
  - starve_cnt and wait_cnt are cleared to 0.
  - Reset mid-transaction: mem_req drops in the next cycle and no ready pulse is issued for the aborted access.
- State machine: IDLE -> BUS -> DONE -> IDLE.
- IDLE:
  - Grant rules:
    - If d_req=1 and not (if_req=1 and starve_cnt==STARVE_LIMIT), grant data.
    - Else if if_req=1, grant fetch.
    - Else stay in IDLE.
  - On grant, register owner, mem_addr, mem_we (d_we for data, 0 for fetch) and mem_wdata (d_wdata for data; for fetch hold the previous value), set mem_req=1, clear wait_cnt, go to BUS.
  - Starvation counter:
    - Data grant with if_req=1: starve_cnt increments, saturating at STARVE_LIMIT.
    - Fetch grant: starve_cnt clears to 0.
    - Data grant with if_req=0: starve_cnt clears to 0.
- BUS:
  - mem_req=1 and the mem_* outputs are held constant.
  - On mem_ack=1:
    - Capture mem_rdata into if_rdata (fetch owner) or d_rdata (data load).
    - On stores d_rdata keeps its previous value.
    - mem_req and mem_we go to 0 and the state goes to DONE.
  - A zero-wait ack (mem_ack=1 in the first BUS cycle) is legal.
  - Timeout: wait_cnt increments each BUS cycle without ack. If ack has not arrived by BUS cycle TIMEOUT (wait_cnt==TIMEOUT-1), then:
    - go to DONE with err set;
    - mem_req is therefore high for exactly TIMEOUT cycles;
    - the owner's rdata is set to 0.
- DONE:
  - The owner's ready=1 for exactly one cycle, with bus_err=err; clear err.
  - Request inputs are ignored in this cycle; next state is IDLE.
  - The requester updates or drops its req at the edge ending DONE.
- Latency: from a request seen in IDLE to ready is 2 + (BUS cycles). Minimum is 3 cycles per access, so back-to-back throughput is one access per 3 cycles with zero-wait memory.
- mem_ack outside BUS is ignored.
- mem_addr and mem_wdata hold their last values outside BUS; mem_we is 0 outside BUS.
- if_ready and d_ready are never high in the same cycle.
- busy is registered and equals (state != IDLE).

Test Plan:
- Fetch only, if_addr=0x10, mem_ack in 3rd BUS cycle with mem_rdata=0x00000013 -> mem_req high cycles 1-3, if_ready=1 with if_rdata=0x13 in cycle 4, bus_err=0.
- Simultaneous if_req and d_req (store, d_addr=0x200, d_wdata=0xDEADBEEF), zero-wait ack -> first BUS cycle has mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF; d_ready in cycle 2; fetch granted in cycle 3; if_ready in cycle 5.
- d_req and if_req held high continuously, STARVE_LIMIT=4, zero-wait acks -> grant order D,D,D,D,F,D,D,D,D,F; starve_cnt returns to 0 after each F.
- Load with no mem_ack, TIMEOUT=8 -> mem_req high exactly 8 cycles, then d_ready=1, bus_err=1, d_rdata=0; next access completes normally with bus_err=0.
- reset=0 asserted in 2nd BUS cycle, mem_ack=1 the following cycle -> mem_req=0 the cycle after reset, no ready pulse, state IDLE, all outputs 0; the stray ack has no effect.
- Back-to-back loads at 0x40 then 0x44 (mem_rdata 0xAAAA0001 / 0xAAAA0002), zero-wait -> d_ready pulses 3 cycles apart with the matching data, busy=0 only in the IDLE cycles.
